i2c_slave: RTL and testbench
============================

I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter SLAVE_ADDR, default 7'h2A: the 7-bit bus address this block answers to.
REQ-003 Port clk  input  1  system clock; every flop in the block is clocked on its rising edge.
REQ-004 Port rst  input  1  asynchronous reset, active-low (0 = reset).
REQ-005 Port i2c_scl  input  1  bus clock from the master; this block never drives it and never stretches it.
REQ-006 Port i2c_sda  inout  1  bus data, open-drain: the block drives only 0 or Z, never 1.
REQ-007 Port tx_data  input  8  byte returned on read transfers; captured when tx_load pulses.
REQ-008 Port rx_data  output  8  last byte received in a write transfer.
REQ-009 Port rx_valid  output  1  one-clk pulse; rx_data is new and stable.
REQ-010 Port tx_load  output  1  one-clk pulse in the same cycle that tx_data is captured.
REQ-011 Port busy  output  1  high from a START until a STOP, or until the block drops back to IDLE.

Function
REQ-012 SHALL pass i2c_scl and i2c_sda through 2-flop synchronizers; all bus events are detected on the synchronized copies.
REQ-013 Clocking constraint: SCL high time and SCL low time are each at least 4 clk cycles (at least 8 when filtering is enabled).
REQ-014 Event definitions: START = SDA falls while SCL is high; STOP = SDA rises while SCL is high; rise/fall = SCL edge on the synchronized copy.
REQ-015 Data handling: SDA is sampled on SCL rise; the block changes SDA only on SCL fall, within 1 clk of the fall.
REQ-016 States: IDLE, ADDR, ADDR_ACK, WRITE_DATA, WRITE_ACK, READ_DATA, READ_ACK, WAIT_STOP.
REQ-017 START from any state → ADDR, with the bit counter cleared; this covers repeated START.
REQ-018 STOP from any state → IDLE, with SDA released.
REQ-019 ADDR: shift 8 bits MSB first, 7 address bits then rw.
- On a match with SLAVE_ADDR → ADDR_ACK.
- On a mismatch → WAIT_STOP, with SDA never driven.
REQ-020 ADDR_ACK: drive SDA=0 from the SCL fall after bit 8 to the next SCL fall.
- rw=0 → WRITE_DATA.
- rw=1 → pulse tx_load, capture tx_data, → READ_DATA.
REQ-021 WRITE_DATA: shift in 8 bits MSB first.
- After the 8th rise, update rx_data and pulse rx_valid in the same cycle.
- Then ACK as in REQ-020 (WRITE_ACK) and return to WRITE_DATA for the next byte.
REQ-022 READ_DATA: drive the captured byte MSB first; drive 0 for a 0 bit and Z for a 1 bit.
- Release SDA on the SCL fall after bit 8 → READ_ACK.
REQ-023 READ_ACK: sample SDA on SCL rise.
- 0 (ACK) → pulse tx_load, capture the next byte, → READ_DATA.
- 1 (NACK) → WAIT_STOP.
REQ-024 WAIT_STOP: SDA released; ignore all SCL activity until a STOP or START.
REQ-025 Simultaneous STOP and SCL edge detection in one cycle: STOP has priority.
REQ-026 A STOP mid-byte discards the partial byte: no rx_valid pulse, rx_data unchanged.

Reset
REQ-027 While rst=0, the block SHALL hold these values:
- state IDLE, SDA released (Z).
- rx_data=8'h00, rx_valid=0, tx_load=0, busy=0, bit counter=0.
- synchronizer flops = 1.
REQ-028 Assertion of rst mid-transfer SHALL release SDA combinationally, without waiting for clk.
REQ-029 After release, the block SHALL ignore the bus until the next START.

Configuration
REQ-030 Macro I2C_SLAVE_GLITCH_FILTER_EN defined: after the synchronizers, SCL and SDA each pass through a 3-sample majority filter, adding 2 clk of latency; pulses of 1 clk are suppressed.
REQ-031 Macro I2C_SLAVE_GLITCH_FILTER_EN undefined: no filter; event latency is exactly the 2-clk synchronizer delay.

Verification
REQ-032 Write test: START, addr 0x2A, rw=0, byte 0x5C, STOP → ACK at both 9th clocks; rx_data=0x5C; exactly one rx_valid pulse.
REQ-033 Read test: START, 0x2A, rw=1, tx_data=0xA5, master NACK, STOP → SDA pattern 10100101 on the bus; exactly one tx_load pulse; SDA released at the NACK.
REQ-034 Address mismatch: START, 0x15, rw=0, byte 0xFF, STOP → SDA never driven 0; no rx_valid; busy falls at STOP.
REQ-035 Multi-byte: write 0x01, 0x02, 0x03 → three rx_valid pulses in order. Read with ACK, ACK, NACK → three tx_load pulses.
REQ-036 STOP after 4 bits of a data byte → no rx_valid; rx_data keeps its prior value; state is IDLE.
REQ-037 rst=0 asserted during ADDR_ACK → SDA goes to Z immediately; all outputs hold reset values. A full write after release completes correctly.

Source files
------------

// File: rtl/i2c_slave.sv
// i2c_slave: 7-bit addressed I2C target with one byte of write/read data per
// transfer phase and streaming multi-byte support in both directions.
// SCL is only observed and never stretched; SDA is open-drain (0 or Z only).
// Both bus lines pass through two-flop synchronizers; all START/STOP and
// SCL edge detection works on the synchronized copies.
// Optional build macro I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority
// filter behind each synchronizer (2 extra clk of latency, 1-clk pulses
// removed). Without it the event latency is just the synchronizer delay.
module i2c_slave #(
   parameter logic [6:0] SLAVE_ADDR = 7'h2A
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i2c_scl,
   inout  wire        i2c_sda,
   input  logic [7:0] tx_data,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       tx_load,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WRITE_DATA,
      WRITE_ACK,
      READ_DATA,
      READ_ACK,
      WAIT_STOP
   } state_t;

   // Bus line conditioning: bit 0 carries SCL, bit 1 carries SDA.
   logic [1:0] line_raw;
   logic [1:0] line_bus;

   assign line_raw = {i2c_sda, i2c_scl};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_line
         logic meta_reg;
         logic sync_reg;

         // Two-flop synchronizer; resets to the idle (high) bus level.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               meta_reg <= 1'b1;
               sync_reg <= 1'b1;
            end else begin
               meta_reg <= line_raw[gi];
               sync_reg <= meta_reg;
            end
         end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
         logic [1:0] hist_reg;
         logic       filt_reg;
         logic       vote;

         // Majority of the newest synchronized sample and the two before it.
         assign vote = (sync_reg & hist_reg[0]) |
                       (sync_reg & hist_reg[1]) |
                       (hist_reg[0] & hist_reg[1]);

         // Sample history plus registered vote: two clk of added latency.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               hist_reg <= 2'b11;
               filt_reg <= 1'b1;
            end else begin
               hist_reg <= {hist_reg[0], sync_reg};
               filt_reg <= vote;
            end
         end

         assign line_bus[gi] = filt_reg;
`else
         assign line_bus[gi] = sync_reg;
`endif
      end
   endgenerate

   logic scl_bus;
   logic sda_bus;
   logic scl_prev_reg;
   logic sda_prev_reg;

   assign scl_bus = line_bus[0];
   assign sda_bus = line_bus[1];

   // Previous conditioned levels, used to find edges and bus conditions.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_prev_reg <= 1'b1;
         sda_prev_reg <= 1'b1;
      end else begin
         scl_prev_reg <= scl_bus;
         sda_prev_reg <= sda_bus;
      end
   end

   logic scl_rise;
   logic scl_fall;
   logic start_det;
   logic stop_det;

   // START/STOP need SCL high in both samples so an SCL edge is never
   // mistaken for a data transition.
   assign scl_rise  = scl_bus & ~scl_prev_reg;
   assign scl_fall  = ~scl_bus & scl_prev_reg;
   assign start_det = scl_bus & scl_prev_reg & sda_prev_reg & ~sda_bus;
   assign stop_det  = scl_bus & scl_prev_reg & ~sda_prev_reg & sda_bus;

   state_t      state_reg, state_next;
   logic [3:0]  bit_cnt_reg, bit_cnt_next;
   logic [6:0]  shift_reg, shift_next;
   logic [7:0]  tx_shift_reg, tx_shift_next;
   logic        rw_reg, rw_next;
   logic        sda_oe_reg, sda_oe_next;
   logic [7:0]  rx_data_reg, rx_data_next;
   logic        rx_valid_reg, rx_valid_next;
   logic        busy_reg, busy_next;
   logic        load_tx;
   logic [7:0]  rx_byte;
   logic [2:0]  tx_idx;

   // Byte as it will look once the bit being sampled now is shifted in.
   assign rx_byte = {shift_reg, sda_bus};
   // Bit of the read byte to present after the current SCL fall.
   assign tx_idx  = 3'd7 - bit_cnt_reg[2:0];

   // Protocol state and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         bit_cnt_reg  <= 4'd0;
         shift_reg    <= 7'd0;
         tx_shift_reg <= 8'd0;
         rw_reg       <= 1'b0;
         sda_oe_reg   <= 1'b0;
         rx_data_reg  <= 8'h00;
         rx_valid_reg <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         bit_cnt_reg  <= bit_cnt_next;
         shift_reg    <= shift_next;
         tx_shift_reg <= tx_shift_next;
         rw_reg       <= rw_next;
         sda_oe_reg   <= sda_oe_next;
         rx_data_reg  <= rx_data_next;
         rx_valid_reg <= rx_valid_next;
         busy_reg     <= busy_next;
      end
   end

   // Next-state and datapath decode. STOP outranks START, and both outrank
   // any SCL edge seen in the same cycle. SDA only changes on an SCL fall.
   // The ACK states use sda_oe_reg as their phase: the first fall starts
   // driving the ACK low, the second fall ends it.
   always_comb begin
      state_next    = state_reg;
      bit_cnt_next  = bit_cnt_reg;
      shift_next    = shift_reg;
      tx_shift_next = tx_shift_reg;
      rw_next       = rw_reg;
      sda_oe_next   = sda_oe_reg;
      rx_data_next  = rx_data_reg;
      rx_valid_next = 1'b0;
      load_tx       = 1'b0;

      if (stop_det) begin
         state_next   = IDLE;
         bit_cnt_next = 4'd0;
         sda_oe_next  = 1'b0;
      end else if (start_det) begin
         state_next   = ADDR;
         bit_cnt_next = 4'd0;
         sda_oe_next  = 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               sda_oe_next = 1'b0;
            end

            ADDR: begin
               if (scl_rise) begin
                  shift_next = rx_byte[6:0];
                  if (bit_cnt_reg == 4'd7) begin
                     bit_cnt_next = 4'd0;
                     rw_next      = rx_byte[0];
                     if (rx_byte[7:1] == SLAVE_ADDR) begin
                        state_next = ADDR_ACK;
                     end else begin
                        state_next = WAIT_STOP;
                     end
                  end else begin
                     bit_cnt_next = bit_cnt_reg + 4'd1;
                  end
               end
            end

            ADDR_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe_reg) begin
                     sda_oe_next = 1'b1;
                  end else if (rw_reg) begin
                     // ACK ends: fetch the read byte and present its MSB
                     // on the same fall.
                     load_tx       = 1'b1;
                     tx_shift_next = tx_data;
                     sda_oe_next   = ~tx_data[7];
                     bit_cnt_next  = 4'd0;
                     state_next    = READ_DATA;
                  end else begin
                     sda_oe_next  = 1'b0;
                     bit_cnt_next = 4'd0;
                     state_next   = WRITE_DATA;
                  end
               end
            end

            WRITE_DATA: begin
               if (scl_rise) begin
                  shift_next = rx_byte[6:0];
                  if (bit_cnt_reg == 4'd7) begin
                     rx_data_next  = rx_byte;
                     rx_valid_next = 1'b1;
                     bit_cnt_next  = 4'd0;
                     state_next    = WRITE_ACK;
                  end else begin
                     bit_cnt_next = bit_cnt_reg + 4'd1;
                  end
               end
            end

            WRITE_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe_reg) begin
                     sda_oe_next = 1'b1;
                  end else begin
                     sda_oe_next = 1'b0;
                     state_next  = WRITE_DATA;
                  end
               end
            end

            READ_DATA: begin
               // bit_cnt counts bits already clocked out by the master.
               if (scl_rise) begin
                  if (bit_cnt_reg != 4'd8) begin
                     bit_cnt_next = bit_cnt_reg + 4'd1;
                  end
               end else if (scl_fall) begin
                  if (bit_cnt_reg == 4'd8) begin
                     sda_oe_next  = 1'b0;
                     bit_cnt_next = 4'd0;
                     state_next   = READ_ACK;
                  end else begin
                     sda_oe_next = ~tx_shift_reg[tx_idx];
                  end
               end
            end

            READ_ACK: begin
               if (scl_rise) begin
                  if (!sda_bus) begin
                     // Master wants another byte; its MSB goes out on the
                     // next fall from READ_DATA with bit_cnt at zero.
                     load_tx       = 1'b1;
                     tx_shift_next = tx_data;
                     bit_cnt_next  = 4'd0;
                     state_next    = READ_DATA;
                  end else begin
                     state_next = WAIT_STOP;
                  end
               end
            end

            WAIT_STOP: begin
               sda_oe_next = 1'b0;
            end

            default: begin
               state_next  = IDLE;
               sda_oe_next = 1'b0;
            end
         endcase
      end

      busy_next = (state_next != IDLE);
   end

   assign rx_data  = rx_data_reg;
   assign rx_valid = rx_valid_reg;
   assign tx_load  = load_tx;
   assign busy     = busy_reg;

   // Open-drain SDA; reset gates the enable so the line lets go without
   // waiting for a clock edge.
   assign i2c_sda = (sda_oe_reg && rst) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master driving i2c_slave through a table of
// transactions plus hand-written mid-byte STOP and reset-during-ACK cases.
// Received bytes are checked through an expected/observed scoreboard.
module tb_i2c_slave;

   typedef struct {
      logic [6:0]      addr;
      logic            rd;
      int              n;
      logic [2:0][7:0] d;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       scl_m;
   logic       sda_low_m;
   wire        sda_bus;
   logic [7:0] tx_data;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_load;
   logic       busy;

   logic [7:0] tx_list [4];
   int         tx_base = 0;
   int         tx_cnt = 0;
   int         rx_cnt = 0;
   int         slave_low_cnt = 0;
   int         busy_cyc = 0;
   logic       tx_load_d = 1'b0;
   logic [7:0] rx_obs_q [$];
   logic [7:0] rx_exp_q [$];
   int         rx_rd_idx = 0;
   int         checks = 0;
   int         failures = 0;
   logic [7:0] last_rx = 8'h00;
   vec_t       tbl [6];

   assign sda_bus = sda_low_m ? 1'b0 : 1'bz;
   pullup (sda_bus);

   // Read data source; advances one cycle after each load pulse.
   assign tx_data = tx_list[2'(tx_cnt - tx_base)];

   i2c_slave #(.SLAVE_ADDR(7'h2A)) dut (
      .clk      (clk),
      .rst      (rst),
      .i2c_scl  (scl_m),
      .i2c_sda  (sda_bus),
      .tx_data  (tx_data),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_load  (tx_load),
      .busy     (busy)
   );

   // Observation on the falling edge: pulse counters and received bytes.
   always @(negedge clk) begin
      tx_load_d <= tx_load;
      if (tx_load_d) tx_cnt <= tx_cnt + 1;
      if (rx_valid) begin
         rx_cnt <= rx_cnt + 1;
         rx_obs_q.push_back(rx_data);
      end
      if (sda_bus === 1'b0 && !sda_low_m) slave_low_cnt <= slave_low_cnt + 1;
      if (busy) busy_cyc <= busy_cyc + 1;
   end

   task automatic clk_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // One SCL period; enters and leaves with SCL low. b=1 releases SDA.
   task automatic send_bit(input logic b, output logic sampled);
      clk_wait(5);
      sda_low_m = ~b;
      clk_wait(5);
      scl_m = 1'b1;
      clk_wait(5);
      sampled = sda_bus;
      clk_wait(5);
      scl_m = 1'b0;
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) send_bit(b[i], s);
      send_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] data, output logic line);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'b1, s);
         data[i] = s;
      end
      send_bit(nack, line);
   endtask

   task automatic i2c_start();
      sda_low_m = 1'b0;
      scl_m     = 1'b1;
      clk_wait(10);
      sda_low_m = 1'b1;
      clk_wait(10);
      scl_m = 1'b0;
   endtask

   task automatic i2c_stop();
      clk_wait(5);
      sda_low_m = 1'b1;
      clk_wait(5);
      scl_m = 1'b1;
      clk_wait(10);
      sda_low_m = 1'b0;
      clk_wait(10);
   endtask

   // Pop every expected byte and compare against what the monitor saw.
   task automatic check_scoreboard(input string tag);
      logic [7:0] e;
      while (rx_exp_q.size() > 0) begin
         e = rx_exp_q.pop_front();
         if (rx_rd_idx < rx_obs_q.size()) begin
            chk($sformatf("%s_rx_byte", tag), 32'(rx_obs_q[rx_rd_idx]), 32'(e));
            rx_rd_idx++;
         end else begin
            checks++;
            failures++;
            $display("FAIL %s_rx_missing actual=none required=0x%0h", tag, e);
         end
      end
      chk($sformatf("%s_rx_extra", tag), 32'(rx_obs_q.size()), 32'(rx_rd_idx));
      rx_rd_idx = rx_obs_q.size();
   endtask

   task automatic do_txn(input vec_t v, input string tag);
      int         rx0, tx0, low0, busy0;
      logic       ack, line, match;
      logic [7:0] data;
      match = (v.addr == 7'h2A);
      rx0   = rx_cnt;
      tx0   = tx_cnt;
      low0  = slave_low_cnt;
      busy0 = busy_cyc;
      for (int k = 0; k < 3; k++) tx_list[k] = v.d[k];
      tx_list[3] = 8'h00;
      tx_base = tx_cnt;
      i2c_start();
      write_byte({v.addr, v.rd}, ack);
      chk($sformatf("%s_addr_ack", tag), 32'(ack), match ? 32'd0 : 32'd1);
      if (match && !v.rd) begin
         for (int k = 0; k < v.n; k++) begin
            rx_exp_q.push_back(v.d[k]);
            write_byte(v.d[k], ack);
            chk($sformatf("%s_data_ack%0d", tag, k), 32'(ack), 32'd0);
            last_rx = v.d[k];
         end
      end else if (match) begin
         for (int k = 0; k < v.n; k++) begin
            read_byte(k == v.n - 1, data, line);
            chk($sformatf("%s_read%0d", tag, k), 32'(data), 32'(v.d[k]));
            if (k == v.n - 1) chk($sformatf("%s_nack_released", tag), 32'(line), 32'd1);
         end
      end else begin
         write_byte(v.d[0], ack);
         chk($sformatf("%s_ignored_ack", tag), 32'(ack), 32'd1);
      end
      i2c_stop();
      clk_wait(5);
      chk($sformatf("%s_busy_after_stop", tag), 32'(busy), 32'd0);
      chk($sformatf("%s_busy_seen", tag), 32'(busy_cyc > busy0), 32'd1);
      chk($sformatf("%s_rx_pulses", tag), 32'(rx_cnt - rx0), (match && !v.rd) ? 32'(v.n) : 32'd0);
      chk($sformatf("%s_tx_pulses", tag), 32'(tx_cnt - tx0), (match && v.rd) ? 32'(v.n) : 32'd0);
      chk($sformatf("%s_rx_data", tag), 32'(rx_data), 32'(last_rx));
      if (!match) chk($sformatf("%s_sda_untouched", tag), 32'(slave_low_cnt - low0), 32'd0);
      check_scoreboard(tag);
      $display("txn %s addr=0x%0h rd=%0d n=%0d checks=%0d", tag, v.addr, v.rd, v.n, checks);
   endtask

   initial begin
      logic s, ack;
      int   rx0, low0;
      vec_t post;

      tbl[0] = '{addr: 7'h2A, rd: 1'b0, n: 1, d: {8'h00, 8'h00, 8'h5C}};
      tbl[1] = '{addr: 7'h2A, rd: 1'b1, n: 1, d: {8'h00, 8'h00, 8'hA5}};
      tbl[2] = '{addr: 7'h15, rd: 1'b0, n: 1, d: {8'h00, 8'h00, 8'hFF}};
      tbl[3] = '{addr: 7'h2A, rd: 1'b0, n: 3, d: {8'h03, 8'h02, 8'h01}};
      tbl[4] = '{addr: 7'h2A, rd: 1'b1, n: 3, d: {8'h81, 8'hC3, 8'h3C}};
      tbl[5] = '{addr: 7'h2B, rd: 1'b1, n: 1, d: {8'h00, 8'h00, 8'hFF}};
      post   = '{addr: 7'h2A, rd: 1'b0, n: 2, d: {8'h00, 8'hAD, 8'hDE}};
      for (int k = 0; k < 4; k++) tx_list[k] = 8'h00;

      rst       = 1'b0;
      scl_m     = 1'b1;
      sda_low_m = 1'b0;
      clk_wait(5);
      chk("reset_rx_data", 32'(rx_data), 32'h00);
      chk("reset_rx_valid", 32'(rx_valid), 32'd0);
      chk("reset_tx_load", 32'(tx_load), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_sda", 32'(sda_bus), 32'd1);
      rst = 1'b1;
      clk_wait(5);

      for (int i = 0; i < 6; i++) do_txn(tbl[i], $sformatf("vec%0d", i));

      // STOP after four bits of a data byte: partial byte discarded.
      rx0 = rx_cnt;
      i2c_start();
      write_byte(8'h54, ack);
      chk("midstop_addr_ack", 32'(ack), 32'd0);
      send_bit(1'b1, s);
      send_bit(1'b0, s);
      send_bit(1'b1, s);
      send_bit(1'b1, s);
      i2c_stop();
      clk_wait(5);
      chk("midstop_rx_pulses", 32'(rx_cnt - rx0), 32'd0);
      chk("midstop_rx_data", 32'(rx_data), 32'(last_rx));
      chk("midstop_idle", 32'(busy), 32'd0);
      $display("txn midstop rx_data=0x%0h", rx_data);

      // Reset asserted while the address ACK is on the bus.
      rx0 = rx_cnt;
      i2c_start();
      for (int i = 7; i >= 0; i--) send_bit(((8'h54 >> i) & 8'h01) != 8'h00, s);
      clk_wait(1);
      sda_low_m = 1'b0;
      clk_wait(7);
      chk("ackrst_ack_driven", 32'(sda_bus), 32'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("ackrst_sda_released", 32'(sda_bus), 32'd1);
      chk("ackrst_busy", 32'(busy), 32'd0);
      chk("ackrst_rx_valid", 32'(rx_valid), 32'd0);
      chk("ackrst_tx_load", 32'(tx_load), 32'd0);
      chk("ackrst_rx_data", 32'(rx_data), 32'h00);
      last_rx = 8'h00;
      clk_wait(3);
      rst = 1'b1;
      low0 = slave_low_cnt;
      clk_wait(3);
      scl_m = 1'b1;
      clk_wait(10);
      scl_m = 1'b0;
      i2c_stop();
      clk_wait(5);
      chk("ackrst_ignored_bus", 32'(slave_low_cnt - low0), 32'd0);
      chk("ackrst_rx_pulses", 32'(rx_cnt - rx0), 32'd0);
      chk("ackrst_idle", 32'(busy), 32'd0);
      $display("txn ackrst busy=%0d", busy);

      do_txn(post, "postrst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
